// File: rtl/regfile_pkg.sv
// Shared widths and types for the register file write path.
// PC_ADDR is never written through the port.
package regfile_pkg;

  localparam int AW = 4;
  localparam int DW = 32;

  localparam logic [3:0] PC_ADDR = 4'd15;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward, wrapping.
// Grants at most one requester, and none when en is low.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  // first valid requester after the last one granted
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port among NREQ writers.
// Writes to the PC register are accepted but dropped and counted.
module regfile_wr_arbiter #(
  parameter  int NREQ = 2,
  parameter  int AW   = regfile_pkg::AW,
  parameter  int DW   = regfile_pkg::DW,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int PM   = 1 << AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic             stall,
  output logic             we3,
  output logic [AW-1:0]    ra3,
  output logic [DW-1:0]    wd3,
  output logic [IW-1:0]    grant_id,
  output logic [PM-1:0]    pend_mask,
  output logic [7:0]       drop_cnt
);

  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gid;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic            to_pc;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (last_grant),
    .en  (!stall && rst_n),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign any       = |gnt;

  // one-hot grant to index
  always_comb begin
    gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gid = IW'(i);
    end
  end

  assign sel_addr = req_addr[gid*AW +: AW];
  assign sel_data = req_data[gid*DW +: DW];
  assign to_pc    = (sel_addr == AW'(regfile_pkg::PC_ADDR));

  // pointer, output stage and dropped-write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NREQ - 1);
      we3        <= 1'b0;
      ra3        <= '0;
      wd3        <= '0;
      grant_id   <= '0;
      pend_mask  <= '0;
      drop_cnt   <= '0;
    end else begin
      if (any) last_grant <= gid;
      if (any && !to_pc) begin
        we3       <= 1'b1;
        ra3       <= sel_addr;
        wd3       <= sel_data;
        grant_id  <= gid;
        pend_mask <= {{(PM-1){1'b0}}, 1'b1} << sel_addr;
      end else begin
        we3       <= 1'b0;
        pend_mask <= '0;
      end
      if (any && to_pc && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed cases plus random traffic
// compared against a round-robin reference model.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            stall;
  logic            we3;
  logic [AW-1:0]   ra3;
  logic [DW-1:0]   wd3;
  logic [IW-1:0]   grant_id;
  logic [15:0]     pend_mask;
  logic [7:0]      drop_cnt;

  logic    v[N];
  wr_req_t rq[N];

  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = v[i];
      req_addr[i*AW +: AW] = rq[i].addr;
      req_data[i*DW +: DW] = rq[i].data;
    end
  end

  regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .stall     (stall),
    .we3       (we3),
    .ra3       (ra3),
    .wd3       (wd3),
    .grant_id  (grant_id),
    .pend_mask (pend_mask),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  int            lg;
  bit            m_we;
  logic [AW-1:0] m_ra;
  logic [DW-1:0] m_wd;
  int            m_gid;
  int            m_drop;
  int            waitc[N];
  int            last_g;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (stall) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    lg     = N - 1;
    m_we   = 1'b0;
    m_ra   = '0;
    m_wd   = '0;
    m_gid  = 0;
    m_drop = 0;
    last_g = -1;
    for (int i = 0; i < N; i++) waitc[i] = 0;
  endtask

  // one clock: check ready, advance the model, check the port
  task automatic cycle();
    int g;
    g = pick();
    #1;
    check("ready", 64'(req_ready), g >= 0 ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    if (g >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == g) waitc[i] = 0;
        else if (v[i]) begin
          waitc[i]++;
          check("fair_wait", 64'(waitc[i] <= N - 1), 64'd1);
        end
      end
      lg = g;
      if (rq[g].addr == AW'(PC_ADDR)) begin
        m_we = 1'b0;
        if (m_drop < 255) m_drop++;
      end else begin
        m_we  = 1'b1;
        m_ra  = rq[g].addr;
        m_wd  = rq[g].data;
        m_gid = g;
      end
    end else begin
      m_we = 1'b0;
    end
    last_g = g;
    @(negedge clk);
    check("we3", 64'(we3), 64'(m_we));
    check("ra3", 64'(ra3), 64'(m_ra));
    check("wd3", 64'(wd3), 64'(m_wd));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("pend_mask", 64'(pend_mask), m_we ? (64'd1 << m_ra) : 64'd0);
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (last_g == i || !v[i]) begin
        v[i]       = ($urandom_range(0, 3) != 0);
        rq[i].addr = ($urandom_range(0, 7) == 0) ? AW'(PC_ADDR)
                                                 : AW'($urandom_range(0, 15));
        rq[i].data = $urandom;
        waitc[i]   = 0;
      end else if ($urandom_range(0, 19) == 0) begin
        v[i]     = 1'b0;
        waitc[i] = 0;
      end
    end
    stall = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i]  = 1'b1;
      rq[i] = '0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_ra3", 64'(ra3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_pend", 64'(pend_mask), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    rst_n = 1'b1;

    // single write
    v[0]  = 1'b1;
    rq[0] = '{addr: 4'd1, data: 32'hAAAA_AAAA};
    cycle();
    check("single_we", 64'(we3), 64'd1);
    check("single_wd", 64'(wd3), 64'hAAAA_AAAA);
    check("single_pend", 64'(pend_mask), 64'h0002);
    v[0] = 1'b0;
    cycle();
    check("single_idle", 64'(we3), 64'd0);

    // contention after reset: 0,1,0,1...
    do_reset();
    v[0]  = 1'b1;
    v[1]  = 1'b1;
    rq[0] = '{addr: 4'd3, data: 32'h0000_0033};
    rq[1] = '{addr: 4'd4, data: 32'h0000_0044};
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("contend_gid", 64'(grant_id), 64'(k % 2));
      check("contend_we", 64'(we3), 64'd1);
    end

    // stall three cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k > 0) check("stall_we", 64'(we3), 64'd0);
    end
    stall = 1'b0;
    cycle();
    check("stall_resume", 64'(grant_id), 64'd0);

    // same address, grant order decides
    do_reset();
    rq[0] = '{addr: 4'd2, data: 32'h1111_1111};
    rq[1] = '{addr: 4'd2, data: 32'hABCD_1110};
    v[0]  = 1'b1;
    v[1]  = 1'b1;
    cycle();
    check("same_first", 64'(wd3), 64'h1111_1111);
    v[0] = 1'b0;
    cycle();
    check("same_last", 64'(wd3), 64'hABCD_1110);
    check("same_addr", 64'(ra3), 64'd2);
    v[1] = 1'b0;

    // r15 writes are dropped and counted
    do_reset();
    v[1]  = 1'b1;
    rq[1] = '{addr: 4'd15, data: 32'hFFFF_FFFF};
    cycle();
    check("r15_we", 64'(we3), 64'd0);
    check("r15_drop1", 64'(drop_cnt), 64'd1);
    repeat (299) cycle();
    check("r15_sat", 64'(drop_cnt), 64'd255);

    // reset while a write is on the port
    v[1]  = 1'b0;
    v[0]  = 1'b1;
    rq[0] = '{addr: 4'd5, data: 32'h5555_0005};
    cycle();
    check("mid_we_before", 64'(we3), 64'd1);
    v[1]  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_we", 64'(we3), 64'd0);
    check("mid_pend", 64'(pend_mask), 64'd0);
    check("mid_drop", 64'(drop_cnt), 64'd0);
    check("mid_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("mid_first", 64'(grant_id), 64'd0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rand_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port (we3/ra3/wd3) between NREQ writeback requesters, e.g. ALU result and load data. Each requester uses a valid/ready handshake. A round-robin arbiter grants at most one request per cycle, and a registered output stage drives the write port. Writes addressed to r15 are rejected: r15 is supplied externally as the PC, never written through the port.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 4, register address width
- DW, 32, data width
- clk  input  1  rising-edge clock, shared with the register file
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_ready  output  NREQ  requester i granted this cycle (one-hot or zero)
- req_addr  input  NREQ*AW  destination register; slice i = [i*AW +: AW]
- req_data  input  NREQ*DW  write data; slice i = [i*DW +: DW]
- stall  input  1  when high, no grants are issued
- we3  output  1  register file write enable
- ra3  output  AW  register file write address
- wd3  output  DW  register file write data
- grant_id  output  $clog2(NREQ)  index of the requester whose write is on the port
- pend_mask  output  2**AW  one-hot of ra3 while we3 is high, else 0 (read-hazard hint)
- drop_cnt  output  8  saturating count of rejected r15 writes

## Operation
- Arbitration:
  - Round-robin search starts at (last_grant+1) mod NREQ.
  - The first requester with req_valid high is granted: req_ready[i]=1, combinational from req_valid, last_grant and stall.
  - last_grant updates only on a grant.
- stall=1 forces req_ready to all zeros and leaves last_grant unchanged. A write already in the output stage still issues.
- Accepted write (valid&ready, addr≠15): next cycle we3=1, ra3=addr, wd3=data, grant_id=i, pend_mask=1<<addr.
- Accepted write to addr 15 (PC_ADDR):
  - The handshake completes (ready=1) and the write is discarded.
  - Next cycle we3=0, pend_mask=0.
  - drop_cnt increments, saturating at 255.
- No grant: next cycle we3=0, pend_mask=0. ra3/wd3/grant_id hold their previous values.
- Requesters hold valid, addr and data stable until ready. Dropping valid before ready is legal; the request simply disappears.
- A requester may stay valid on consecutive cycles. With several valid requesters, grants rotate; no requester waits more than NREQ-1 grants.

## Timing
- Latency: accept in cycle N, port driven during cycle N+1, register file captures at the rising edge ending N+1. Readback via ra1/ra2 is valid from cycle N+2.
- Throughput: one write per cycle when not stalled.
- Reset (rst_n low, asynchronous):
  - we3=0, ra3=0, wd3=0, grant_id=0, pend_mask=0, drop_cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready is forced to 0 while rst_n is low.
- Reset asserted mid-operation: the write in the output stage is lost (we3 drops immediately). No write issues in the first cycle after release.
- stall and a grant in the same cycle: stall wins.
- Two valid requesters both targeting the same address: writes issue in grant order, so the last granted value persists.

## Structure
- Package regfile_pkg holds AW, DW, PC_ADDR=4'd15 and typedef wr_req_t {logic [AW-1:0] addr; logic [DW-1:0] data;}.
- Sub-module rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt) contains the rotate-and-priority logic.
- The top level holds last_grant, the output register stage, the r15 filter and drop_cnt.

## Test plan
- Single write: req0 valid, addr=1, data=32'hAAAA_AAAA → ready0 for one cycle; next cycle we3=1, ra3=1, wd3=AAAA_AAAA, pend_mask=16'h0002; ra1=1 reads AAAA_AAAA from N+2.
- Contention: req0 and req1 both valid continuously with distinct addresses → grants after reset are 0,1,0,1…; we3 stays high every cycle.
- r15 rejection: req1 addr=15, data=32'hFFFF_FFFF → ready1=1, next cycle we3=0, drop_cnt 0→1; 300 such writes leave drop_cnt=255.
- Stall: both requesters valid, stall=1 for 3 cycles → no ready, we3=0 from the second stalled cycle; after release, the grant goes to the index after last_grant.
- Same-address ordering: req0 writes 32'h1111_1111 and req1 writes 32'hABCD_1110 to addr 2 in the same cycle → after both issue, reg2 holds the later-granted value per the rotation.
- Reset mid-operation: assert rst_n=0 while we3=1 → we3, pend_mask, drop_cnt go to 0 asynchronously; after release, first grant goes to req0.
